// File: rtl/newspaper_pkg.sv
// Coin codes shared between the coin acceptor and the newspaper vending FSM.
// Pure declarations: no latency, no flow control.
package newspaper_pkg;

    typedef logic [1:0] coin_t;

    localparam coin_t COIN_NONE = 2'b00;
    localparam coin_t COIN_5    = 2'b01;
    localparam coin_t COIN_10   = 2'b10;

endpackage

// File: rtl/coin_debounce.sv
// One sensor channel: 2-flop sync, stability counter, rise strobe (combinational, valid the
// edge stable goes 0->1), DEBOUNCE_CYCLES+2 edges after the raw rise; no backpressure.
module coin_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_in,
    output logic rise
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d  = raw_in;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        rise     = 1'b0;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            stable_d = sync2_q;
            cnt_d    = '0;
            rise     = sync2_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // stable resets high so a sensor stuck high through reset must go low before it can count.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b1;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/coin_acceptor.sv
// Debounced nickel/dime sensors -> coin FIFO -> registered one-cycle coin codes; coin one edge
// after push when idle. hold stalls the output (coins kept); pushes into a full FIFO are rejected.
module coin_acceptor
    import newspaper_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        nickel_in,
    input  logic                        dime_in,
    input  logic                        hold,
    output coin_t                       coin,
    output logic                        reject,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

    logic nickel_rise;
    logic dime_rise;

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_nickel (
        .clock  (clock),
        .reset  (reset),
        .raw_in (nickel_in),
        .rise   (nickel_rise)
    );

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dime (
        .clock  (clock),
        .reset  (reset),
        .raw_in (dime_in),
        .rise   (dime_rise)
    );

    coin_t          mem_q [FIFO_DEPTH];
    coin_t          mem_d [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]  level_q, level_d;
    coin_t          coin_q, coin_d;
    logic           reject_q, reject_d;

    logic  push_req;
    logic  jam;
    logic  full;
    logic  do_push;
    logic  do_pop;
    coin_t push_code;

    always_comb begin
        push_req  = nickel_rise ^ dime_rise;
        jam       = nickel_rise & dime_rise;
        push_code = nickel_rise ? COIN_5 : COIN_10;
        // Full is judged on the pre-edge level, so a same-edge pop does not rescue the coin.
        full      = (level_q == LEVEL_FULL);
        do_push   = push_req && !full;
        do_pop    = (level_q != '0) && !hold;
        reject_d  = jam || (push_req && full);
        coin_d    = do_pop ? mem_q[rd_ptr_q] : COIN_NONE;

        mem_d = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_code;
        end

        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= COIN_NONE;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            coin_q   <= COIN_NONE;
            reject_q <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            coin_q   <= coin_d;
            reject_q <= reject_d;
        end
    end

    assign coin       = coin_q;
    assign reject     = reject_q;
    assign fifo_level = level_q;

endmodule

// File: doc/coin_acceptor.md
Name: coin_acceptor

Overview:
- Front-end stage for the newspaper vending FSM. Converts two raw, bouncy coin-slot sensor lines (nickel, dime) into clean coin codes on the 2-bit coin bus that the FSM consumes.
- Synchronises and debounces each sensor, detects coin insertions and rejects jams.
- Buffers accepted coins in a small FIFO and holds them off while the vending FSM is dispensing, so no credit is lost.

Parameters:
- DEBOUNCE_CYCLES, 16: number of consecutive stable synchronised samples required before a sensor level change is accepted; must be >= 2.
- FIFO_DEPTH, 4: accepted-coin buffer depth; power of 2, >= 2.

Ports:
- clock  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- nickel_in  input  1  raw 5-unit sensor; asynchronous and bouncy; high = coin present.
- dime_in  input  1  raw 10-unit sensor; asynchronous and bouncy; high = coin present.
- hold  input  1  high = downstream is dispensing; do not present coins. Driven from the FSM's newspaper output.
- coin  output  2  registered coin code: 00 none, 01 five, 10 ten; never 11.
- reject  output  1  registered one-cycle pulse: coin routed to the return chute (jam or FIFO full).
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current number of buffered coins.

Behaviour:
- Reset (synchronous, active-high; also mid-operation):
  - coin=00, reject=0, fifo_level=0; FIFO pointers cleared; sync flops cleared.
  - Debounce counters = 0. Debounced level ("stable") = 1 on both channels.
- Arming after reset: stable resets to 1, so a sensor stuck high through reset never produces a coin. A channel must first debounce low before its next rising edge counts.
- Synchroniser: 2 flops per channel; sync2 is the second flop.
- Debounce, per channel, at each edge:
  - If sync2 == stable: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= sync2, cnt <= 0.
  - Else: cnt <= cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES samples leaves stable unchanged.
- Rise event: a channel's stable goes 0->1 at this edge. Falling transitions generate nothing.
- Classification, evaluated at the edge where stable updates:
  - Nickel rise only: push 01.
  - Dime rise only: push 10.
  - Both rise at the same edge: jam. No push; reject=1 for the next cycle.
  - Push while FIFO full (level == FIFO_DEPTH before the edge): coin dropped, reject=1. This applies even if a pop occurs at the same edge.
- Output stage, at each edge:
  - If FIFO non-empty and hold==0: coin <= head, pop.
  - Otherwise coin <= 00.
  - Consecutive buffered coins are presented on back-to-back cycles with no idle gap.
- Latency: nickel_in high first sampled at edge 1 -> pushed at edge DEBOUNCE_CYCLES+2 -> coin=01 visible after edge DEBOUNCE_CYCLES+3, for exactly one cycle. This assumes an empty FIFO and hold=0.
- Simultaneous push and pop (not full): both take effect; level unchanged.
- hold asserted: coin=00 from the next edge; buffered coins and level retained. Pushes still accepted while hold is high.
- Pointer wrap: modulo FIFO_DEPTH. Level is separate so full and empty are unambiguous.
- reject and a valid coin may be active in the same cycle.

Decomposition:
- Shared package newspaper_pkg:
  - COIN_NONE=2'b00, COIN_5=2'b01, COIN_10=2'b10.
  - Coin-code typedef (2-bit), shared with the vending FSM.
- Sub-module coin_debounce (2-flop sync + counter + stable + rise strobe; parameter DEBOUNCE_CYCLES), instantiated twice.
- FIFO and output stage are inline in coin_acceptor.

Test Plan (bench overrides DEBOUNCE_CYCLES=4, FIFO_DEPTH=4):
- Post-reset arming: hold sensors low for 7 cycles after reset, then nickel_in high at edge 1 -> coin=01 for one cycle after edge 7; fifo_level returns to 0.
- Bounce: dime_in toggles 1,0,1,0 on successive cycles, then stays high -> exactly one coin=10; no reject; a 3-cycle glitch alone produces nothing.
- Jam: nickel_in and dime_in rise together and stay high -> no coin; reject=1 for one cycle after edge 6.
- Hold and burst: hold=1; insert nickel, dime, nickel, dime (each debounced) -> fifo_level=4, coin=00; a 5th nickel gives reject=1, level stays 4. Release hold -> coin 01,10,01,10 on 4 consecutive cycles, then 00.
- Stuck sensor: nickel_in held high through and after reset -> no coin ever. Drive low 4+ cycles, then high -> one coin=01.
- Reset mid-operation: with level=3 and coin pending, assert reset for one edge -> next cycle coin=00, fifo_level=0, reject=0; no buffered coin is emitted later.
